// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Shares one single-port memory bus between instruction fetch and data
//   load/store. Each instruction walks FETCH -> DECODE -> [DATA] -> COMMIT.
//   COMMIT raises a one-cycle iready pulse so the pc block can advance.
//   A busy watchdog, a terminal HALT state and a retired-instruction counter
//   are included.
//
//   Bus handshake: a strobe (bus_ren/bus_wen) is held with stable address,
//   data and byte enables until a cycle in which bus_busy=0. That cycle
//   completes the access, and bus_rdata is valid in it for reads.
//   The strobes are decoded from registered state only, so no combinational
//   path runs from bus_busy to the strobes.
//
// Ports
//   clk, nRST            clock, asynchronous active-low reset
//   PCaddr               fetch address from the pc block
//   dmem_ren/dmem_wen    load/store request, valid in DECODE
//   dmem_addr/wdata/sel  data access attributes, sampled in DECODE
//   halt                 stop after the current instruction (seen in COMMIT)
//   bus_rdata, bus_busy  memory response
//   bus_addr/wdata/sel   memory request attributes
//   bus_ren, bus_wen     memory strobes
//   instr, dmem_rdata    latched instruction and load data
//   iready               one-cycle retire pulse
//   halted, bus_err      HALT state flag, sticky error flag
//   instr_count          retired-instruction counter (wraps)
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] NOP_INSN = 32'h13
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [31:0]      PCaddr,
  input  logic             dmem_ren,
  input  logic             dmem_wen,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wdata,
  input  logic [3:0]       dmem_sel,
  input  logic             halt,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_busy,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  output logic [3:0]       bus_sel,
  output logic             bus_ren,
  output logic             bus_wen,
  output logic [31:0]      instr,
  output logic [31:0]      dmem_rdata,
  output logic             iready,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_DATA,
    S_COMMIT,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        sel_q;
  logic              ren_q, wen_q;
  logic              load_instr, load_data, sample_req, retire, err_set;
  logic              wd_expired;

  // This busy cycle is the TIMEOUT-th one in the current access.
  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    load_instr = 1'b0;
    load_data  = 1'b0;
    sample_req = 1'b0;
    retire     = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!bus_busy) begin
          load_instr = 1'b1;
          state_d    = S_DECODE;
        end else if (wd_expired) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        sample_req = 1'b1;
        if (dmem_ren && dmem_wen) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else if (dmem_ren || dmem_wen) begin
          state_d = S_DATA;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_DATA: begin
        if (!bus_busy) begin
          load_data = ren_q;
          state_d   = S_COMMIT;
        end else if (wd_expired) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_COMMIT: begin
        retire  = 1'b1;
        state_d = halt ? S_HALT : S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Watchdog restarts on every state change, so it measures one access only.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) begin
      wd_d = '0;
    end else if ((state_q == S_FETCH || state_q == S_DATA) && bus_busy) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_FETCH;
      wd_q        <= '0;
      instr       <= NOP_INSN;
      dmem_rdata  <= '0;
      instr_count <= '0;
      bus_err     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (load_instr) instr <= bus_rdata;
      if (load_data)  dmem_rdata <= bus_rdata;
      if (retire)     instr_count <= instr_count + 1'b1;
      if (err_set)    bus_err <= 1'b1;
      if (sample_req) begin
        addr_q  <= dmem_addr;
        wdata_q <= dmem_wdata;
        sel_q   <= dmem_sel;
        ren_q   <= dmem_ren;
        wen_q   <= dmem_wen;
      end
    end
  end

  // Gating with nRST drops the strobes the moment reset asserts, even
  // though the reset state is FETCH.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_sel   = '0;
    bus_ren   = 1'b0;
    bus_wen   = 1'b0;
    if (nRST) begin
      case (state_q)
        S_FETCH: begin
          bus_ren  = 1'b1;
          bus_addr = PCaddr;
          bus_sel  = 4'hF;
        end
        S_DATA: begin
          bus_ren   = ren_q;
          bus_wen   = wen_q;
          bus_addr  = addr_q;
          bus_wdata = wdata_q;
          bus_sel   = sel_q;
        end
        default: ;
      endcase
    end
  end

  assign iready = (state_q == S_COMMIT);
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        nRST;
  logic [31:0] PCaddr;
  logic        dmem_ren, dmem_wen;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_sel;
  logic        halt;
  logic [31:0] bus_rdata;
  logic        bus_busy;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ren, bus_wen;
  logic [31:0] instr, dmem_rdata;
  logic        iready, halted, bus_err;
  logic [3:0]  instr_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mem_access_ctrl #(.TIMEOUT(6), .CNT_W(4), .NOP_INSN(32'h13)) dut (
    .clk(clk), .nRST(nRST), .PCaddr(PCaddr),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_sel(dmem_sel), .halt(halt),
    .bus_rdata(bus_rdata), .bus_busy(bus_busy),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .instr(instr),
    .dmem_rdata(dmem_rdata), .iready(iready), .halted(halted),
    .bus_err(bus_err), .instr_count(instr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        busy;
    logic [31:0] rdata;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [3:0]  dsel;
    logic        ren_e;
    logic        wen_e;
    logic [31:0] addr_e;
    logic [3:0]  sel_e;
    logic [31:0] wdata_e;
    logic        ir_e;
    logic [31:0] instr_e;
    logic [31:0] drd_e;
    logic [3:0]  cnt_e;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] pc, input logic busy, input logic [31:0] rdata,
                     input logic dren, input logic dwen, input logic [31:0] daddr,
                     input logic [31:0] dwd, input logic [3:0] dsel,
                     input logic ren_e, input logic wen_e, input logic [31:0] addr_e,
                     input logic [3:0] sel_e, input logic [31:0] wdata_e, input logic ir_e,
                     input logic [31:0] instr_e, input logic [31:0] drd_e, input logic [3:0] cnt_e);
    vec_t v;
    v = '{pc, busy, rdata, dren, dwen, daddr, dwd, dsel,
          ren_e, wen_e, addr_e, sel_e, wdata_e, ir_e, instr_e, drd_e, cnt_e};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    PCaddr = '0; dmem_ren = 0; dmem_wen = 0; dmem_addr = '0;
    dmem_wdata = '0; dmem_sel = '0; halt = 0; bus_rdata = '0; bus_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 with reset released; the DUT is in FETCH.
  task automatic do_reset(input bit check_it);
    nRST = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check_it) begin
      chk("rst_ren", 32'(bus_ren), 32'd0);
      chk("rst_wen", 32'(bus_wen), 32'd0);
      chk("rst_instr", instr, 32'h13);
      chk("rst_drd", dmem_rdata, 32'd0);
      chk("rst_cnt", 32'(instr_count), 32'd0);
      chk("rst_iready", 32'(iready), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_err", 32'(bus_err), 32'd0);
    end
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b0;

    // ---------------- table: alu, load, busy store, busy fetch ----------------
    add(32'h0, 0, 32'h00500093, 0, 0, 0, 0, 0,           1, 0, 32'h0,   4'hF, 0, 0,           32'h13,       0, 0);
    add(32'h0, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 0,                     32'h00500093, 0, 0);
    add(32'h0, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 1,                     32'h00500093, 0, 0);
    add(32'h4, 0, 32'h00002003, 0, 0, 0, 0, 0,           1, 0, 32'h4,   4'hF, 0, 0,           32'h00500093, 0, 1);
    add(32'h4, 0, 0, 1, 0, 32'h100, 0, 4'hF,             0, 0, 0, 0, 0, 0,                     32'h00002003, 0, 1);
    add(32'h4, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0,           1, 0, 32'h100, 4'hF, 0, 0,           32'h00002003, 0, 1);
    add(32'h4, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 1,                     32'h00002003, 32'hDEADBEEF, 1);
    add(32'h8, 0, 32'h00302023, 0, 0, 0, 0, 0,           1, 0, 32'h8,   4'hF, 0, 0,           32'h00002003, 32'hDEADBEEF, 2);
    add(32'h8, 0, 0, 0, 1, 32'h200, 32'hCAFEF00D, 4'b0011, 0, 0, 0, 0, 0, 0,                  32'h00302023, 32'hDEADBEEF, 2);
    for (int i = 0; i < 5; i++)
      add(32'h8, 1, 0, 0, 0, 0, 0, 0,                    0, 1, 32'h200, 4'b0011, 32'hCAFEF00D, 0, 32'h00302023, 32'hDEADBEEF, 2);
    add(32'h8, 0, 32'h12345678, 0, 0, 0, 0, 0,           0, 1, 32'h200, 4'b0011, 32'hCAFEF00D, 0, 32'h00302023, 32'hDEADBEEF, 2);
    add(32'h8, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 1,                     32'h00302023, 32'hDEADBEEF, 2);
    add(32'hC, 1, 0, 0, 0, 0, 0, 0,                      1, 0, 32'hC,   4'hF, 0, 0,           32'h00302023, 32'hDEADBEEF, 3);
    add(32'hC, 1, 0, 0, 0, 0, 0, 0,                      1, 0, 32'hC,   4'hF, 0, 0,           32'h00302023, 32'hDEADBEEF, 3);
    add(32'hC, 0, 32'h00000013, 0, 0, 0, 0, 0,           1, 0, 32'hC,   4'hF, 0, 0,           32'h00302023, 32'hDEADBEEF, 3);
    add(32'hC, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 0,                     32'h00000013, 32'hDEADBEEF, 3);
    add(32'hC, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 1,                     32'h00000013, 32'hDEADBEEF, 3);
    add(32'h10, 1, 0, 0, 0, 0, 0, 0,                     1, 0, 32'h10,  4'hF, 0, 0,           32'h00000013, 32'hDEADBEEF, 4);

    do_reset(1'b1);
    foreach (vecs[i]) begin
      PCaddr = vecs[i].pc; bus_busy = vecs[i].busy; bus_rdata = vecs[i].rdata;
      dmem_ren = vecs[i].dren; dmem_wen = vecs[i].dwen; dmem_addr = vecs[i].daddr;
      dmem_wdata = vecs[i].dwd; dmem_sel = vecs[i].dsel; halt = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_ren", i), 32'(bus_ren), 32'(vecs[i].ren_e));
      chk($sformatf("v%0d_wen", i), 32'(bus_wen), 32'(vecs[i].wen_e));
      chk($sformatf("v%0d_addr", i), bus_addr, vecs[i].addr_e);
      chk($sformatf("v%0d_sel", i), 32'(bus_sel), 32'(vecs[i].sel_e));
      chk($sformatf("v%0d_wdata", i), bus_wdata, vecs[i].wdata_e);
      chk($sformatf("v%0d_iready", i), 32'(iready), 32'(vecs[i].ir_e));
      chk($sformatf("v%0d_instr", i), instr, vecs[i].instr_e);
      chk($sformatf("v%0d_drd", i), dmem_rdata, vecs[i].drd_e);
      chk($sformatf("v%0d_cnt", i), 32'(instr_count), 32'(vecs[i].cnt_e));
      tick();
    end

    // ---------------- 16 back-to-back ALU insns: period 3, count 10, wrap ----------------
    idle_inputs();
    do_reset(1'b0);
    for (int c = 0; c < 48; c++) begin
      PCaddr = 32'(c / 3) * 4;
      bus_rdata = 32'h00100093 + (32'(c / 3) << 7);
      if (c % 3 == 0) exp_q.push_back(bus_rdata);
      @(negedge clk);
      chk($sformatf("seq_iready_c%0d", c), 32'(iready), 32'(c % 3 == 2));
      if (iready) begin
        if (exp_q.size() == 0) chk("seq_exp_q_empty", 32'd1, 32'd0);
        else chk($sformatf("seq_instr_c%0d", c), instr, exp_q.pop_front());
      end
      if (c == 30) chk("seq_cnt10", 32'(instr_count), 32'd10);
      tick();
    end
    @(negedge clk);
    chk("seq_cnt_wrap", 32'(instr_count), 32'd0);
    chk("seq_q_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- watchdog: fetch stuck busy, TIMEOUT=6 ----------------
    idle_inputs();
    bus_busy = 1'b1;
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("wd_ren_b%0d", i + 1), 32'(bus_ren), 32'd1);
      chk($sformatf("wd_halted_b%0d", i + 1), 32'(halted), 32'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wd_err", 32'(bus_err), 32'd1);
      chk("wd_halted", 32'(halted), 32'd1);
      chk("wd_ren", 32'(bus_ren), 32'd0);
      chk("wd_iready", 32'(iready), 32'd0);
      chk("wd_cnt", 32'(instr_count), 32'd0);
      tick();
    end

    // ---------------- ren & wen conflict in DECODE ----------------
    idle_inputs();
    bus_rdata = 32'h00000033;
    do_reset(1'b0);
    tick();                       // FETCH completes
    dmem_ren = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h300;
    @(negedge clk);
    chk("cf_decode_ren", 32'(bus_ren), 32'd0);
    tick();
    dmem_ren = 1'b0; dmem_wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cf_err", 32'(bus_err), 32'd1);
      chk("cf_halted", 32'(halted), 32'd1);
      chk("cf_strobes", {30'd0, bus_ren, bus_wen}, 32'd0);
      chk("cf_iready", 32'(iready), 32'd0);
      chk("cf_cnt", 32'(instr_count), 32'd0);
      tick();
    end

    // ---------------- halt held from FETCH: waits for COMMIT, one iready ----------------
    begin
      int pulses;
      pulses = 0;
      idle_inputs();
      halt = 1'b1;
      bus_busy = 1'b1;
      PCaddr = 32'h20;
      do_reset(1'b0);
      for (int c = 0; c < 10; c++) begin
        if (c == 2) begin bus_busy = 1'b0; bus_rdata = 32'h00000013; end
        @(negedge clk);
        if (iready) pulses++;
        if (c < 2) chk("hl_wait_halted", 32'(halted), 32'd0);
        tick();
      end
      @(negedge clk);
      chk("hl_pulses", 32'(pulses), 32'd1);
      chk("hl_halted", 32'(halted), 32'd1);
      chk("hl_err", 32'(bus_err), 32'd0);
      chk("hl_cnt", 32'(instr_count), 32'd1);
      chk("hl_ren", 32'(bus_ren), 32'd0);
    end

    // ---------------- reset asserted mid-DATA while busy ----------------
    idle_inputs();
    PCaddr = 32'h40;
    bus_rdata = 32'h00002083;
    do_reset(1'b0);
    tick();                                   // FETCH done
    dmem_ren = 1'b1; dmem_addr = 32'h300; dmem_sel = 4'hF;
    tick();                                   // DECODE done
    dmem_ren = 1'b0;
    bus_rdata = 32'hAAAA5555;
    tick();                                   // DATA done, load latched
    tick();                                   // COMMIT
    bus_rdata = 32'h00002103;
    tick();                                   // FETCH done
    dmem_ren = 1'b1; dmem_addr = 32'h304;
    tick();                                   // DECODE done
    dmem_ren = 1'b0;
    bus_busy = 1'b1;
    @(negedge clk);
    chk("mr_data_ren", 32'(bus_ren), 32'd1);
    chk("mr_data_addr", bus_addr, 32'h304);
    chk("mr_drd_before", dmem_rdata, 32'hAAAA5555);
    #1 nRST = 1'b0;
    #1;
    chk("mr_ren", 32'(bus_ren), 32'd0);
    chk("mr_wen", 32'(bus_wen), 32'd0);
    chk("mr_instr", instr, 32'h13);
    chk("mr_cnt", 32'(instr_count), 32'd0);
    chk("mr_drd", dmem_rdata, 32'd0);
    tick();
    nRST = 1'b1;
    PCaddr = 32'h44;
    @(negedge clk);
    chk("mr_fetch_ren", 32'(bus_ren), 32'd1);
    chk("mr_fetch_addr", bus_addr, 32'h44);
    chk("mr_fetch_sel", 32'(bus_sel), 32'hF);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
